// File: rtl/heartbeat_responder_pkg.sv
// Width helpers for the heartbeat responder and its reply queue.
package heartbeat_responder_pkg;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Holdoff counter width, at least one bit so a zero holdoff still elaborates.
  function automatic int unsigned holdoff_cnt_w(input int unsigned holdoff);
    return (holdoff == 0) ? 1 : $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/types.sv
// Node-ID type shared by the heartbeat requester and responder.
package types;

  localparam int unsigned NODE_ID_W = 8;

  typedef logic [NODE_ID_W-1:0] node_id_t;

endpackage

// File: rtl/heartbeat_reply_queue.sv
// Circular FIFO of pending requester IDs with a parallel membership compare
// against the incoming requester, used to suppress duplicate replies.
module heartbeat_reply_queue
  import types::*;
  import heartbeat_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   nocclk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  node_id_t               push_id,
  input  node_id_t               query_id,
  output node_id_t               head_id,
  output logic                   hit,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = count_w(DEPTH);

  node_id_t         mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [DEPTH-1:0] entry_match;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_match[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count)
                       && (mem[i] == query_id);
    end
  end

  assign hit     = |entry_match;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = mem[rd_ptr];

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/heartbeat_responder.sv
// Answering end of the heartbeat protocol: queues distinct requesters addressed
// to this node and presents one reply destination at a time with a holdoff.
module heartbeat_responder
  import types::*;
  import heartbeat_responder_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH   = 4,
  parameter int unsigned REPLY_HOLDOFF = 8
) (
  input  logic                         nocclk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  node_id_t                     this_node_id,
  input  logic                         incoming_flit_valid,
  input  logic                         incoming_flit_is_heartbeat_request,
  input  node_id_t                     incoming_flit_node_id,
  input  node_id_t                     incoming_flit_dst_id,
  input  logic                         reply_ready,
  output logic                         reply_valid,
  output node_id_t                     reply_dst_node_id,
  output logic                         request_dropped,
  output logic                         overflow,
  output logic [$clog2(QUEUE_DEPTH):0] pending_count
);

  localparam int unsigned CNT_W = count_w(QUEUE_DEPTH);
  localparam int unsigned HO_W  = holdoff_cnt_w(REPLY_HOLDOFF);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(REPLY_HOLDOFF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_HOLDOFF
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [HO_W-1:0] holdoff_q;
  logic [HO_W-1:0] holdoff_d;

  logic accept;
  logic q_hit;
  logic q_full;
  logic q_empty;
  logic fire;
  logic push;
  logic drop;
  logic remain;

  // Request decode; dedup covers every live entry, including a head popped now.
  assign accept = incoming_flit_valid && incoming_flit_is_heartbeat_request
                  && (incoming_flit_dst_id == this_node_id);
  assign push   = accept && !q_hit && (!q_full || fire);
  assign drop   = accept && !q_hit && q_full && !fire;

  assign reply_valid = (state_q == ST_PRESENT) && !stall;
  assign fire        = reply_valid && reply_ready;
  assign remain      = (pending_count > CNT_W'(1)) || push;

  heartbeat_reply_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .nocclk   (nocclk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (fire),
    .push_id  (incoming_flit_node_id),
    .query_id (incoming_flit_node_id),
    .head_id  (reply_dst_node_id),
    .hit      (q_hit),
    .full     (q_full),
    .empty    (q_empty),
    .count    (pending_count)
  );

  // Holdoff runs down to zero and leaves on the next unstalled cycle, so the
  // next reply_valid appears REPLY_HOLDOFF+1 unstalled edges after a fire.
  always_comb begin
    state_d   = state_q;
    holdoff_d = holdoff_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!q_empty) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (fire) begin
          if (REPLY_HOLDOFF != 0) begin
            state_d   = ST_HOLDOFF;
            holdoff_d = HO_LOAD;
          end else begin
            state_d = remain ? ST_PRESENT : ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        if (!stall) begin
          if (holdoff_q == '0) state_d = q_empty ? ST_IDLE : ST_PRESENT;
          else                 holdoff_d = holdoff_q - HO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      holdoff_q       <= '0;
      request_dropped <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      state_q         <= state_d;
      holdoff_q       <= holdoff_d;
      request_dropped <= drop;
      if (drop) overflow <= 1'b1;
    end
  end

  a_head_stable: assert property (@(posedge nocclk) disable iff (!rst_n)
    (reply_valid && !reply_ready) |=> (reply_dst_node_id == $past(reply_dst_node_id)));
  a_count_bound: assert property (@(posedge nocclk) disable iff (!rst_n)
    pending_count <= CNT_W'(QUEUE_DEPTH));
  a_no_empty_pop: assert property (@(posedge nocclk) disable iff (!rst_n)
    !(fire && q_empty));

endmodule

// File: tb/tb_heartbeat_responder.sv
// Directed scenarios plus randomized traffic against a queue-level model.
module tb_heartbeat_responder;
  import types::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 8;

  logic     nocclk = 1'b0;
  logic     rst_n, stall, fv, isreq, ready;
  node_id_t me, src, dst;
  logic     reply_valid, request_dropped, overflow;
  node_id_t reply_dst;
  logic [2:0] pending_count;

  int checks   = 0;
  int failures = 0;

  // Model: pending requesters in arrival order, remaining unstalled holdoff
  // edges, and whether the queue was already non-empty before the last edge.
  node_id_t mq[$];
  int       gap;
  bit       prev_ne;
  bit       m_drop;
  bit       m_ovf;

  heartbeat_responder #(.QUEUE_DEPTH(DEPTH), .REPLY_HOLDOFF(HOLD)) dut (
    .nocclk                             (nocclk),
    .rst_n                              (rst_n),
    .stall                              (stall),
    .this_node_id                       (me),
    .incoming_flit_valid                (fv),
    .incoming_flit_is_heartbeat_request (isreq),
    .incoming_flit_node_id              (src),
    .incoming_flit_dst_id               (dst),
    .reply_ready                        (ready),
    .reply_valid                        (reply_valid),
    .reply_dst_node_id                  (reply_dst),
    .request_dropped                    (request_dropped),
    .overflow                           (overflow),
    .pending_count                      (pending_count)
  );

  always #5 nocclk = ~nocclk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_valid();
    return rst_n && !stall && (gap == 0) && prev_ne && (mq.size() != 0);
  endfunction

  function automatic bit in_q(input node_id_t id);
    foreach (mq[i]) if (mq[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit acc, fire_m, hit;
    int sz;
    if (!rst_n) begin
      mq.delete(); gap = 0; prev_ne = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    sz     = mq.size();
    acc    = fv && isreq && (dst == me);
    fire_m = m_valid() && ready;
    hit    = acc && in_q(src);
    m_drop = acc && !hit && (sz >= int'(DEPTH)) && !fire_m;
    if (m_drop) m_ovf = 1'b1;
    if (fire_m) begin
      void'(mq.pop_front());
      gap = int'(HOLD) + 1;
    end else if (!stall && gap > 0) begin
      gap--;
    end
    if (acc && !hit && !m_drop) mq.push_back(src);
    prev_ne = (sz > 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge nocclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    fv = 1'b0; isreq = 1'b0; src = '0; dst = '0; stall = 1'b0;
  endtask

  task automatic send(input node_id_t s);
    fv = 1'b1; isreq = 1'b1; src = s; dst = me;
  endtask

  task automatic do_reset();
    idle(); ready = 1'b0; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(); settle();
    checks++; if (reply_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", reply_valid); end
    checks++; if (reply_dst !== 8'd0) begin failures++; $display("FAIL reset_dst got=%0d exp=0", reply_dst); end
    checks++; if (request_dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%0b exp=0", request_dropped); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
  endtask

  task automatic test_single();
    do_reset(); ready = 1'b1;
    send(8'd3); settle(); tick(); idle(); settle();
    checks++; if (pending_count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", pending_count); end
    checks++; if (reply_valid !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", reply_valid); end
    tick(); settle();
    checks++; if (reply_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", reply_valid); end
    checks++; if (reply_dst !== 8'd3) begin failures++; $display("FAIL single_dst got=%0d exp=3", reply_dst); end
    tick(); settle();
    checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", pending_count); end
    checks++; if (reply_valid !== 1'b0) begin failures++; $display("FAIL single_after got=%0b exp=0", reply_valid); end
  endtask

  task automatic test_dedup();
    do_reset(); ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(8'd5); settle(); tick();
      checks++; if (request_dropped !== 1'b0) begin failures++; $display("FAIL dedup_drop%0d got=%0b exp=0", k, request_dropped); end
    end
    idle(); settle();
    checks++; if (pending_count !== 3'd1) begin failures++; $display("FAIL dedup_count got=%0d exp=1", pending_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL dedup_ovf got=%0b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    node_id_t exp_ord [4];
    int idx;
    exp_ord = '{8'd2, 8'd3, 8'd4, 8'd5};
    do_reset(); ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(node_id_t'(2 + k)); settle(); tick();
      checks++; if (request_dropped !== (k == 4)) begin failures++; $display("FAIL ovf_drop%0d got=%0b exp=%0b", k, request_dropped, (k == 4)); end
    end
    idle(); settle();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", pending_count); end
    tick(); settle();
    checks++; if (request_dropped !== 1'b0) begin failures++; $display("FAIL ovf_pulse got=%0b exp=0", request_dropped); end
    ready = 1'b1; idx = 0;
    for (int c = 0; c < 100 && idx < 4; c++) begin
      settle();
      if (reply_valid) begin
        checks++; if (reply_dst !== exp_ord[idx]) begin failures++; $display("FAIL ovf_order%0d got=%0d exp=%0d", idx, reply_dst, exp_ord[idx]); end
        idx++;
      end
      tick();
    end
    checks++; if (idx != 4) begin failures++; $display("FAIL ovf_drain_timeout got=%0d exp=4", idx); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_hold got=%0b exp=1", overflow); end
  endtask

  task automatic test_holdoff_stall();
    int found;
    do_reset(); ready = 1'b0;
    send(8'd7); settle(); tick();
    send(8'd8); settle(); tick();
    idle(); settle();
    for (int c = 0; c < 10 && !reply_valid; c++) begin tick(); settle(); end
    checks++; if (reply_valid !== 1'b1 || reply_dst !== 8'd7) begin failures++; $display("FAIL hold_first got=%0b/%0d exp=1/7", reply_valid, reply_dst); end
    ready = 1'b1; tick();
    found = -1;
    for (int e = 0; e < 40; e++) begin
      settle();
      if (reply_valid) begin found = e; break; end
      stall = (e >= 1 && e <= 3);
      tick();
    end
    checks++; if (found != 12) begin failures++; $display("FAIL hold_gap got=%0d exp=12", found); end
    checks++; if (reply_dst !== 8'd8) begin failures++; $display("FAIL hold_dst got=%0d exp=8", reply_dst); end
    stall = 1'b1; settle();
    checks++; if (reply_valid !== 1'b0) begin failures++; $display("FAIL stall_valid got=%0b exp=0", reply_valid); end
    tick(); settle();
    checks++; if (pending_count !== 3'd1) begin failures++; $display("FAIL stall_nopop got=%0d exp=1", pending_count); end
    stall = 1'b0;
  endtask

  task automatic test_full_pop();
    node_id_t exp_ord [4];
    int idx;
    exp_ord = '{8'd3, 8'd4, 8'd5, 8'd9};
    do_reset(); ready = 1'b0;
    for (int k = 0; k < 4; k++) begin send(node_id_t'(2 + k)); settle(); tick(); end
    idle(); settle();
    checks++; if (reply_valid !== 1'b1 || reply_dst !== 8'd2) begin failures++; $display("FAIL fullpop_head got=%0b/%0d exp=1/2", reply_valid, reply_dst); end
    ready = 1'b1; send(8'd9); settle(); tick(); idle(); ready = 1'b0; settle();
    checks++; if (request_dropped !== 1'b0) begin failures++; $display("FAIL fullpop_drop got=%0b exp=0", request_dropped); end
    checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL fullpop_count got=%0d exp=4", pending_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%0b exp=0", overflow); end
    ready = 1'b1; idx = 0;
    for (int c = 0; c < 100 && idx < 4; c++) begin
      settle();
      if (reply_valid) begin
        checks++; if (reply_dst !== exp_ord[idx]) begin failures++; $display("FAIL fullpop_order%0d got=%0d exp=%0d", idx, reply_dst, exp_ord[idx]); end
        idx++;
      end
      tick();
    end
    checks++; if (idx != 4) begin failures++; $display("FAIL fullpop_drain_timeout got=%0d exp=4", idx); end
  endtask

  task automatic test_filter();
    do_reset(); ready = 1'b1;
    fv = 1'b1; isreq = 1'b1; src = 8'd4; dst = 8'd2; settle(); tick();
    checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL filter_dst got=%0d exp=0", pending_count); end
    isreq = 1'b0; dst = me; tick();
    checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL filter_type got=%0d exp=0", pending_count); end
    fv = 1'b0; isreq = 1'b1; tick();
    checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL filter_valid got=%0d exp=0", pending_count); end
    idle(); ready = 1'b0; me = 8'd6; send(8'd4); settle(); tick(); idle(); settle();
    checks++; if (pending_count !== 3'd1) begin failures++; $display("FAIL filter_ownid got=%0d exp=1", pending_count); end
    me = 8'd1;
  endtask

  task automatic test_reset_mid();
    do_reset(); ready = 1'b0;
    for (int k = 0; k < 5; k++) begin send(node_id_t'(2 + k)); settle(); tick(); end
    idle(); settle();
    checks++; if (overflow !== 1'b1 || pending_count !== 3'd4) begin failures++; $display("FAIL rstmid_pre got=%0b/%0d exp=1/4", overflow, pending_count); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; settle();
    checks++; if (reply_valid !== 1'b0 || reply_dst !== 8'd0) begin failures++; $display("FAIL rstmid_reply got=%0b/%0d exp=0/0", reply_valid, reply_dst); end
    checks++; if (request_dropped !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%0b/%0b exp=0/0", request_dropped, overflow); end
    checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", pending_count); end
    tick(); settle();
    checks++; if (reply_valid !== 1'b0 || pending_count !== 3'd0) begin failures++; $display("FAIL rstmid_after got=%0b/%0d exp=0/0", reply_valid, pending_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      stall = ($urandom_range(0, 9) == 0);
      ready = 1'($urandom_range(0, 1));
      fv    = ($urandom_range(0, 3) != 0);
      isreq = ($urandom_range(0, 4) != 0);
      src   = node_id_t'($urandom_range(0, 7));
      dst   = ($urandom_range(0, 3) == 0) ? 8'd2 : me;
      settle();
      if (rst_n) begin
        checks++; if (reply_valid !== m_valid()) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, reply_valid, m_valid()); end
        if (m_valid()) begin
          checks++; if (reply_dst !== mq[0]) begin failures++; $display("FAIL rnd_dst n=%0d got=%0d exp=%0d", n, reply_dst, mq[0]); end
        end
        checks++; if (pending_count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, pending_count, mq.size()); end
        checks++; if (request_dropped !== m_drop) begin failures++; $display("FAIL rnd_drop n=%0d got=%0b exp=%0b", n, request_dropped, m_drop); end
        checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%0b exp=%0b", n, overflow, m_ovf); end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    me = 8'd1; ready = 1'b0; rst_n = 1'b0;
    idle();
    test_reset();
    test_single();
    test_dedup();
    test_overflow();
    test_holdoff_stall();
    test_full_pop();
    test_filter();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
